// File: rtl/lc3b_types.sv
// Shared LC-3b types for the cache line-transfer path.
// Line, index and responder FSM types used by pmem_responder.
package lc3b_types;

  localparam int unsigned PMEM_LINE_OFFSET_BITS = 4;
  localparam int unsigned PMEM_INDEX_BITS = 12;

  typedef logic [127:0] lc3b_c_line;
  typedef logic [PMEM_INDEX_BITS-1:0] lc3b_pmem_index;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_e;

endpackage

// File: rtl/pmem_array.sv
// Line store for pmem_responder: single port,
// registered read, synchronous write, contents not reset.
module pmem_array
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = PMEM_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] idx,
  input  lc3b_c_line            wdata,
  output lc3b_c_line            rdata
);

  lc3b_c_line mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for 128-bit lines.
// Define PMEM_PROTO_CHECK_EN to build the sticky protocol checker.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned INDEX_BITS = PMEM_INDEX_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  lc3b_c_line   pmem_wdata,
  output lc3b_c_line   pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_state_e           state, state_n;
  logic [7:0]            cnt, cnt_n;
  pmem_op_e              op_q, op_in;
  logic [INDEX_BITS-1:0] idx_q, idx_in, idx;
  lc3b_c_line            wdata_q;
  logic                  req_in, req_live, accept;
  logic                  we, re;
  logic                  unused_addr_bits;

  assign unused_addr_bits = &{1'b0, pmem_address[3:0]};

  assign req_in   = pmem_read | pmem_write;
  assign op_in    = pmem_write ? OP_WRITE : OP_READ;
  assign idx_in   = pmem_address[INDEX_BITS+3:4];
  assign req_live = (op_q == OP_WRITE) ? pmem_write : pmem_read;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_in) begin
          accept  = 1'b1;
          cnt_n   = LAT_M1;
          state_n = (LAT_M1 == 8'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req_live) begin
          cnt_n   = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) state_n = RESP;
        end
      end
      RESP: begin
        cnt_n   = 8'd0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = 8'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      idx_q   <= idx_in;
      wdata_q <= pmem_wdata;
    end
  end

  // Read is launched one cycle ahead so the registered line lands in RESP.
  always_comb begin
    re = 1'b0;
    if (!rst) begin
      if (state == IDLE)
        re = req_in && (op_in == OP_READ) && (LAT_M1 == 8'd0);
      else if (state == BUSY)
        re = req_live && (op_q == OP_READ) && (cnt == 8'd1);
    end
  end

  assign pmem_resp = (state == RESP) && req_live && !rst;
  assign we        = pmem_resp && (op_q == OP_WRITE);
  assign idx       = (state == IDLE) ? idx_in : idx_q;

  pmem_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (pmem_rdata)
  );

`ifdef PMEM_PROTO_CHECK_EN
  logic err_q, viol, busy_chg;

  assign busy_chg = (state == BUSY) &&
                    ((op_in != op_q) || (idx_in != idx_q) ||
                     (pmem_wdata != wdata_q));
  assign viol = (pmem_read & pmem_write) | busy_chg |
                ((state != IDLE) && !req_live);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench for pmem_responder.
// Covers LATENCY=8 and LATENCY=1 instances sharing clk/rst.
module tb_pmem_responder;

`ifdef PMEM_PROTO_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;

  logic         r8_read = 0, r8_write = 0;
  logic [15:0]  r8_addr = '0;
  logic [127:0] r8_wdata = '0, r8_rdata;
  logic         r8_resp, r8_err;

  logic         r1_read = 0, r1_write = 0;
  logic [15:0]  r1_addr = '0;
  logic [127:0] r1_wdata = '0, r1_rdata;
  logic         r1_resp, r1_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.LATENCY(8), .INDEX_BITS(12)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (r8_read),
    .pmem_write   (r8_write),
    .pmem_address (r8_addr),
    .pmem_wdata   (r8_wdata),
    .pmem_rdata   (r8_rdata),
    .pmem_resp    (r8_resp),
    .proto_err    (r8_err)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(12)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (r1_read),
    .pmem_write   (r1_write),
    .pmem_address (r1_addr),
    .pmem_wdata   (r1_wdata),
    .pmem_rdata   (r1_rdata),
    .pmem_resp    (r1_resp),
    .proto_err    (r1_err)
  );

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [127:0] d);
    if (sel) begin
      r1_read = rd; r1_write = wr; r1_addr = a; r1_wdata = d;
    end else begin
      r8_read = rd; r8_write = wr; r8_addr = a; r8_wdata = d;
    end
  endtask

  // rc = cycle of pmem_resp relative to first request cycle, -1 if none
  task automatic do_req(input bit sel, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [127:0] d,
                        input int drop_at, input bit chain,
                        output int rc, output logic [127:0] rdat);
    rc = -1;
    rdat = '0;
    drive(sel, rd, wr, a, d);
    for (int k = 0; k < 20; k++) begin
      if (k == drop_at) drive(sel, 1'b0, 1'b0, a, d);
      @(negedge clk);
      if (sel ? r1_resp : r8_resp) begin
        rc = k;
        rdat = sel ? r1_rdata : r8_rdata;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!chain) drive(sel, 1'b0, 1'b0, 16'h0, '0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (r8_resp !== 1'b0 || r1_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got %b/%b expected 0/0", r8_resp, r1_resp);
    end
    checks++;
    if (r8_rdata !== '0 || r1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", r8_rdata);
    end
    checks++;
    if (r8_err !== 1'b0 || r1_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b/%b expected 0/0", r8_err, r1_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int rc;
    logic [127:0] rd;
    logic [127:0] pat = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_req(0, 1'b0, 1'b1, 16'h1230, pat, -1, 0, rc, rd);
    checks++;
    if (rc !== 8) begin
      errors++;
      $display("FAIL wr_latency: got %0d expected 8", rc);
    end
    do_req(0, 1'b1, 1'b0, 16'h1230, '0, -1, 0, rc, rd);
    checks++;
    if (rc !== 8) begin
      errors++;
      $display("FAIL rd_latency: got %0d expected 8", rc);
    end
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL rd_data: got %h expected %h", rd, pat);
    end
  endtask

  task automatic test_offset_ignored();
    int rc;
    logic [127:0] rd;
    logic [127:0] pat = {16{8'hAA}};
    do_req(0, 1'b0, 1'b1, 16'h0040, pat, -1, 0, rc, rd);
    checks++;
    if (rc !== 8) begin
      errors++;
      $display("FAIL off_wr_latency: got %0d expected 8", rc);
    end
    do_req(0, 1'b1, 1'b0, 16'h004F, '0, -1, 0, rc, rd);
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL off_rd_data: got %h expected %h", rd, pat);
    end
  endtask

  task automatic test_back_to_back();
    int rc1, rc2, c0;
    logic [127:0] rd;
    logic [127:0] pat = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
    c0 = cyc;
    do_req(0, 1'b0, 1'b1, 16'h3330, pat, -1, 1, rc1, rd);
    do_req(0, 1'b1, 1'b0, 16'h3330, '0, -1, 0, rc2, rd);
    checks++;
    if (rc1 !== 8 || rc2 !== 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d,%0d expected 8,8", rc1, rc2);
    end
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL b2b_data: got %h expected %h", rd, pat);
    end
    checks++;
    if (cyc - c0 !== 18) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d expected 18", cyc - c0);
    end
  endtask

  task automatic test_abort();
    int rc;
    logic [127:0] rd;
    do_req(0, 1'b1, 1'b0, 16'h1230, '0, 3, 0, rc, rd);
    checks++;
    if (rc !== -1) begin
      errors++;
      $display("FAIL abort_resp: got %0d expected -1", rc);
    end
    checks++;
    if (r8_err !== EXP_ERR) begin
      errors++;
      $display("FAIL abort_err: got %b expected %b", r8_err, EXP_ERR);
    end
  endtask

  task automatic test_mid_reset();
    int rc;
    logic [127:0] rd;
    logic [127:0] p55 = {16{8'h55}};
    do_req(0, 1'b0, 1'b1, 16'h2000, p55, -1, 0, rc, rd);
    checks++;
    if (rc !== 8) begin
      errors++;
      $display("FAIL rst_pre_wr: got %0d expected 8", rc);
    end
    drive(0, 1'b0, 1'b1, 16'h2000, {16{8'h99}});
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r8_resp !== 1'b0 || r8_rdata !== '0 || r8_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: got resp=%b err=%b rdata=%h expected 0",
               r8_resp, r8_err, r8_rdata);
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, '0);
    @(posedge clk); #1;
    do_req(0, 1'b1, 1'b0, 16'h2000, '0, -1, 0, rc, rd);
    checks++;
    if (rc !== 8) begin
      errors++;
      $display("FAIL rst_rd_latency: got %0d expected 8", rc);
    end
    checks++;
    if (rd !== p55) begin
      errors++;
      $display("FAIL rst_rd_data: got %h expected %h", rd, p55);
    end
  endtask

  task automatic test_latency1();
    int rc;
    logic [127:0] rd;
    logic [127:0] pat = 128'hDEADBEEF_00000001_80000000_13579BDF;
    do_req(1, 1'b1, 1'b1, 16'h0100, pat, -1, 0, rc, rd);
    checks++;
    if (rc !== 1) begin
      errors++;
      $display("FAIL lat1_wr_latency: got %0d expected 1", rc);
    end
    do_req(1, 1'b1, 1'b0, 16'h0100, '0, -1, 0, rc, rd);
    checks++;
    if (rc !== 1) begin
      errors++;
      $display("FAIL lat1_rd_latency: got %0d expected 1", rc);
    end
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL lat1_both_is_write: got %h expected %h", rd, pat);
    end
    checks++;
    if (r1_err !== EXP_ERR) begin
      errors++;
      $display("FAIL lat1_err: got %b expected %b", r1_err, EXP_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_offset_ignored();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
